// File: rtl/addr_map_pkg.sv
// Shared types and helpers for the runtime-programmable address map.
//   addr_rule_t     : one {base, len} rule; len == 0 disables it.
//   rule_hit()      : containment test for one rule against one address.
//   soc_slave_e     : SoC slave enumeration (DRAM at 0 ... Debug at 10).
//   SocDefaultBase  : default base of every SoC slave, indexed by soc_slave_e.
//   SocDefaultLen   : default length of every SoC slave, indexed by soc_slave_e.
package addr_map_pkg;

    localparam int unsigned RuleAddrWidth = 64;
    localparam int unsigned NumSocSlaves  = 11;

    typedef logic [RuleAddrWidth-1:0] rule_addr_t;

    typedef struct packed {
        rule_addr_t base;
        rule_addr_t len;
    } addr_rule_t;

    typedef enum logic [3:0] {
        SOC_DRAM   = 4'd0,
        SOC_BOOT   = 4'd1,
        SOC_SRAM   = 4'd2,
        SOC_PERIPH = 4'd3,
        SOC_GPIO   = 4'd4,
        SOC_TIMER  = 4'd5,
        SOC_UART   = 4'd6,
        SOC_SPI    = 4'd7,
        SOC_I2C    = 4'd8,
        SOC_PLIC   = 4'd9,
        SOC_DEBUG  = 4'd10
    } soc_slave_e;

    // Offset form (addr - base < len) never computes base + len, so a rule
    // that ends exactly at the top of the address space cannot overflow.
    function automatic logic rule_hit(input addr_rule_t rule, input rule_addr_t addr);
        return (rule.len != '0) && (addr >= rule.base) && ((addr - rule.base) < rule.len);
    endfunction

    function automatic rule_addr_t soc_base(input soc_slave_e s);
        case (s)
            SOC_DRAM:   return 64'h0000_0000_8000_0000;
            SOC_BOOT:   return 64'h0000_0000_0000_1000;
            SOC_SRAM:   return 64'h0000_0000_0100_0000;
            SOC_PERIPH: return 64'h0000_0000_0200_0000;
            SOC_GPIO:   return 64'h0000_0000_1000_2000;
            SOC_TIMER:  return 64'h0000_0000_0300_0000;
            SOC_UART:   return 64'h0000_0000_1000_0000;
            SOC_SPI:    return 64'h0000_0000_1000_3000;
            SOC_I2C:    return 64'h0000_0000_1000_4000;
            SOC_PLIC:   return 64'h0000_0000_0C00_0000;
            SOC_DEBUG:  return 64'h0000_0000_0000_0000;
            default:    return '0;
        endcase
    endfunction

    function automatic rule_addr_t soc_len(input soc_slave_e s);
        case (s)
            SOC_DRAM:   return 64'h0000_0000_4000_0000;
            SOC_BOOT:   return 64'h0000_0000_0000_1000;
            SOC_SRAM:   return 64'h0000_0000_0001_0000;
            SOC_PERIPH: return 64'h0000_0000_0001_0000;
            SOC_GPIO:   return 64'h0000_0000_0000_1000;
            SOC_TIMER:  return 64'h0000_0000_0000_1000;
            SOC_UART:   return 64'h0000_0000_0000_1000;
            SOC_SPI:    return 64'h0000_0000_0000_1000;
            SOC_I2C:    return 64'h0000_0000_0000_1000;
            SOC_PLIC:   return 64'h0000_0000_0400_0000;
            SOC_DEBUG:  return 64'h0000_0000_0000_1000;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [NumSocSlaves-1:0][RuleAddrWidth-1:0] soc_base_map();
        logic [NumSocSlaves-1:0][RuleAddrWidth-1:0] m;
        for (int i = 0; i < int'(NumSocSlaves); i++) begin
            m[i] = soc_base(soc_slave_e'(4'(i)));
        end
        return m;
    endfunction

    function automatic logic [NumSocSlaves-1:0][RuleAddrWidth-1:0] soc_len_map();
        logic [NumSocSlaves-1:0][RuleAddrWidth-1:0] m;
        for (int i = 0; i < int'(NumSocSlaves); i++) begin
            m[i] = soc_len(soc_slave_e'(4'(i)));
        end
        return m;
    endfunction

    localparam logic [NumSocSlaves-1:0][RuleAddrWidth-1:0] SocDefaultBase = soc_base_map();
    localparam logic [NumSocSlaves-1:0][RuleAddrWidth-1:0] SocDefaultLen  = soc_len_map();

endpackage

// File: rtl/addr_map_match.sv
// Combinational rule matcher with lowest-index priority.
//   rules : rule table (NumRules entries)
//   addr  : address to decode
//   hit   : at least one enabled rule contains addr
//   idx   : lowest matching rule index, DefaultIdx on a miss
module addr_map_match
    import addr_map_pkg::*;
#(
    parameter int unsigned NumRules   = 11,
    parameter int unsigned IdxWidth   = 4,
    parameter int unsigned DefaultIdx = 0
) (
    input  addr_rule_t            rules [NumRules],
    input  rule_addr_t            addr,
    output logic                  hit,
    output logic [IdxWidth-1:0]   idx
);

    logic [NumRules-1:0] hit_vec;

    for (genvar gi = 0; gi < int'(NumRules); gi++) begin : g_hit
        assign hit_vec[gi] = rule_hit(rules[gi], addr);
    end

    // Scan from the top so the lowest matching index is written last.
    always_comb begin
        idx = IdxWidth'(DefaultIdx);
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                idx = IdxWidth'(i);
            end
        end
    end

    assign hit = |hit_vec;

endmodule

// File: rtl/addr_map_unit.sv
// Runtime-programmable address decoder with a one-stage valid/ready pipeline.
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   cfg_we_i/idx/base/len, lock_i  : rule write port and sticky lock request
//   cfg_err_o, locked_o            : rejected-write pulse, lock status
//   req_valid_i/ready_o/addr_i     : lookup request handshake
//   resp_valid_o/ready_i           : result handshake
//   resp_idx_o/hit_o/addr_o        : decoded rule, hit flag, echoed address
//   err_cnt_o                      : saturating count of accepted misses
// AddrWidth must not exceed the package rule width; narrower addresses are
// zero-extended, which leaves the offset comparison exact.
module addr_map_unit
    import addr_map_pkg::*;
#(
    parameter int unsigned NumRules    = 11,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned IdxWidth    = (NumRules > 1) ? $clog2(NumRules) : 1,
    parameter int unsigned DefaultIdx  = 0,
    parameter int unsigned ErrCntWidth = 16,
    parameter logic [NumRules-1:0][AddrWidth-1:0] RstBase   = '0,
    parameter logic [NumRules-1:0][AddrWidth-1:0] RstLength = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_we_i,
    input  logic [IdxWidth-1:0]    cfg_idx_i,
    input  logic [AddrWidth-1:0]   cfg_base_i,
    input  logic [AddrWidth-1:0]   cfg_len_i,
    input  logic                   cfg_lock_i,
    output logic                   cfg_err_o,
    output logic                   locked_o,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [IdxWidth-1:0]    resp_idx_o,
    output logic                   resp_hit_o,
    output logic [AddrWidth-1:0]   resp_addr_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    addr_rule_t             rule_table [NumRules];
    logic                   locked_reg;
    logic                   cfg_err_reg, cfg_err_next;
    logic                   resp_valid_reg;
    logic [IdxWidth-1:0]    resp_idx_reg;
    logic                   resp_hit_reg;
    logic [AddrWidth-1:0]   resp_addr_reg;
    logic [ErrCntWidth-1:0] err_cnt_reg, err_cnt_next;

    logic                   idx_in_range;
    logic                   wr_en;
    logic                   accept;
    logic                   match_hit;
    logic [IdxWidth-1:0]    match_idx;

    assign idx_in_range = (32'(cfg_idx_i) < 32'(NumRules));
    assign wr_en        = cfg_we_i && !locked_reg && idx_in_range;
    assign req_ready_o  = !resp_valid_reg || resp_ready_i;
    assign accept       = req_valid_i && req_ready_o;

    // Rules are held in flops: every rule is compared in parallel each cycle.
    for (genvar gi = 0; gi < int'(NumRules); gi++) begin : g_rule
        addr_rule_t rule_reg;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rule_reg.base <= RuleAddrWidth'(RstBase[gi]);
                rule_reg.len  <= RuleAddrWidth'(RstLength[gi]);
            end else if (wr_en && (cfg_idx_i == IdxWidth'(gi))) begin
                rule_reg.base <= RuleAddrWidth'(cfg_base_i);
                rule_reg.len  <= RuleAddrWidth'(cfg_len_i);
            end
        end

        assign rule_table[gi] = rule_reg;
    end

    // Lookups see the table as it was before this edge's write.
    addr_map_match #(
        .NumRules   (NumRules),
        .IdxWidth   (IdxWidth),
        .DefaultIdx (DefaultIdx)
    ) u_match (
        .rules (rule_table),
        .addr  (RuleAddrWidth'(req_addr_i)),
        .hit   (match_hit),
        .idx   (match_idx)
    );

    always_comb begin
        cfg_err_next = cfg_we_i && (locked_reg || !idx_in_range);
        err_cnt_next = err_cnt_reg;
        if (accept && !match_hit && (err_cnt_reg != '1)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_reg     <= 1'b0;
            cfg_err_reg    <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_idx_reg   <= '0;
            resp_hit_reg   <= 1'b0;
            resp_addr_reg  <= '0;
            err_cnt_reg    <= '0;
        end else begin
            locked_reg  <= locked_reg | cfg_lock_i;
            cfg_err_reg <= cfg_err_next;
            err_cnt_reg <= err_cnt_next;
            if (accept) begin
                resp_valid_reg <= 1'b1;
                resp_idx_reg   <= match_idx;
                resp_hit_reg   <= match_hit;
                resp_addr_reg  <= req_addr_i;
            end else if (resp_ready_i) begin
                resp_valid_reg <= 1'b0;
            end
        end
    end

    assign cfg_err_o    = cfg_err_reg;
    assign locked_o     = locked_reg;
    assign resp_valid_o = resp_valid_reg;
    assign resp_idx_o   = resp_idx_reg;
    assign resp_hit_o   = resp_hit_reg;
    assign resp_addr_o  = resp_addr_reg;
    assign err_cnt_o    = err_cnt_reg;

endmodule

// File: doc/addr_map_unit.md
Name: addr_map_unit

Overview:
- Runtime-programmable SoC address decoder. Successor to the fixed compile-time slave map.
- Holds NumRules base/length rules. Each rule is reset to a parametrised default map and is rewritable until locked.
- Decodes a stream of request addresses to a slave index through a one-stage registered valid/ready pipeline, and counts decode errors.
- Sits in front of the AXI crossbar and feeds its routing select.

Parameters:
- NumRules, 11, number of address rules (slave indices 0..NumRules-1).
- AddrWidth, 64, address, base and length width.
- IdxWidth, $clog2(NumRules), width of the rule index.
- DefaultIdx, 0, index returned on a miss.
- ErrCntWidth, 16, width of the decode-error counter.
- RstBase, all-zero array [NumRules][AddrWidth], reset base of each rule.
- RstLength, all-zero array [NumRules][AddrWidth], reset length of each rule.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, synchronous active-high reset.
- cfg_we_i, input, 1, rule write strobe.
- cfg_idx_i, input, IdxWidth, rule to write.
- cfg_base_i, input, AddrWidth, new base.
- cfg_len_i, input, AddrWidth, new length; 0 disables the rule.
- cfg_lock_i, input, 1, sets the sticky lock.
- cfg_err_o, output, 1, one-cycle pulse on a rejected write.
- locked_o, output, 1, lock status.
- req_valid_i, input, 1, lookup request valid.
- req_ready_o, output, 1, lookup accepted.
- req_addr_i, input, AddrWidth, address to decode.
- resp_valid_o, output, 1, result valid.
- resp_ready_i, input, 1, result consumed.
- resp_idx_o, output, IdxWidth, matched rule, or DefaultIdx on a miss.
- resp_hit_o, output, 1, a rule matched.
- resp_addr_o, output, AddrWidth, echoed request address.
- err_cnt_o, output, ErrCntWidth, saturating miss count.

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - base[i]=RstBase[i], len[i]=RstLength[i].
  - locked_o=0, cfg_err_o=0.
  - resp_valid_o=0, resp_idx_o=0, resp_hit_o=0, resp_addr_o=0.
  - err_cnt_o=0.
  - Reset mid-transaction drops any held response. No handshake completes in that cycle.
- Match rule:
  - Rule i hits iff len[i]!=0, addr>=base[i], and (addr-base[i])<len[i].
  - The subtraction is unsigned AddrWidth. There is no base+len addition, so a rule ending exactly at 2^AddrWidth is legal and does not overflow.
- Priority: when several rules hit, the lowest index wins.
- Miss: resp_hit_o=0 and resp_idx_o=DefaultIdx.
- Pipeline:
  - req_ready_o = !resp_valid_o || resp_ready_i (combinational).
  - A handshake (req_valid_i && req_ready_o) loads idx, hit and addr into the output register. resp_valid_o=1 the next cycle, so latency is 1.
  - With resp_ready_i held high, throughput is one request per cycle.
  - When resp_valid_o && resp_ready_i and there is no new handshake, resp_valid_o falls the next cycle.
  - Outputs stay stable while resp_valid_o && !resp_ready_i.
- Error counter: increments by 1 on each accepted request that misses, counted at acceptance. It saturates at all-ones with no wrap.
- Config write:
  - When cfg_we_i && !locked_o, base/len[cfg_idx_i] update at the clock edge.
  - A lookup accepted in the same cycle decodes against the old table. The new value is visible to requests accepted from the next cycle on.
  - cfg_idx_i >= NumRules: write ignored, cfg_err_o pulses next cycle.
  - cfg_we_i while locked_o=1: write ignored, cfg_err_o pulses next cycle.
- Lock:
  - cfg_lock_i sets locked_o at the next edge. Only reset clears it.
  - cfg_we_i together with cfg_lock_i while unlocked: the write is applied and the lock is set at the same edge, with no error.
- Overlapping rules are legal. Priority resolves them, and no error is raised.
- No state machine beyond the output register, the lock flag, the counter and the rule table.

Decomposition:
- Shared package addr_map_pkg:
  - typedef addr_rule_t {base, len}.
  - Functions rule_hit(rule, addr) and the default-map constants built from the SoC base/length enum (DRAM at index 0 … Debug at index 10).
- One sub-module, addr_map_match: purely combinational. It takes the rule array and the address and produces {hit, idx} with a lowest-index priority encoder.
- addr_map_unit owns the registers, the handshake, the lock and the counter.

Test Plan:
1. Default map:
   - Reset with DRAM rule 0 (0x8000_0000, 0x4000_0000) and UART rule 6 (0x1000_0000, 0x1000).
   - Lookup 0x8000_0010 -> next cycle hit=1, idx=0.
   - Lookup 0x1000_0FFF -> idx=6.
   - Lookup 0x1000_1000 -> hit=0, idx=DefaultIdx, err_cnt=1.
2. Backpressure:
   - Hold resp_ready_i=0 for 3 cycles with req_valid_i=1.
   - req_ready_o=0 and outputs are stable.
   - Release -> 4 consecutive addresses return in order, one per cycle.
3. Config/lock:
   - Write rule 1 = (0x6000_0000, 0x1_0000) with a lookup of 0x6000_0000 in the same cycle -> that lookup misses; the next lookup hits idx=1.
   - Assert cfg_lock_i, then write rule 1 -> cfg_err_o pulses once and the rule is unchanged.
   - cfg_idx_i=11 with NumRules=11 -> cfg_err_o pulses.
4. Boundaries:
   - Rule 2 = (0xFFFF_FFFF_FFFF_F000, 0x1000): lookup 0xFFFF_FFFF_FFFF_FFFF -> hit idx=2.
   - len=0 -> never hits.
   - Overlapping rules 3 and 4 both cover 0x4000_0000 -> idx=3.
5. Counter saturation: with ErrCntWidth=4, 20 misses -> err_cnt_o=15.
6. Reset mid-stream:
   - Assert rst_i while resp_valid_o=1 and locked_o=1.
   - Next cycle: resp_valid_o=0, locked_o=0, err_cnt_o=0, and the rules are back to their defaults.
